dt_engine_param: RTL
====================

Name: dt_engine_param

Overview:
- Parametrised two-pass chamfer distance-transform engine; successor to the fixed 128x128, 8-bit, chessboard-only DT block.
- Reads a packed binary image from the stimulus ROM. Writes per-pixel distance-to-background into the result RAM.
- Adds configurable image size, ROM word width and distance width, a run-time metric select, saturation, and a forward-pass-finish flag.

Parameters:
- IMG_W, 128, image width in pixels; must be a multiple of STI_W.
- IMG_H, 128, image height in pixels.
- STI_W, 16, pixels per stimulus ROM word.
- DIST_W, 8, result pixel width; distances saturate at 2^DIST_W-1.
- STI_AW, clog2(IMG_W*IMG_H/STI_W), stimulus address width.
- RES_AW, clog2(IMG_W*IMG_H), result address width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- mode, input, 1, 0 = city-block (4-neighbour), 1 = chessboard (8-neighbour); sampled on the first clk after reset release.
- sti_rd, output, 1, stimulus ROM read enable.
- sti_addr, output, STI_AW, stimulus word address.
- sti_di, input, STI_W, stimulus word; pixel x maps to bit STI_W-1-(x mod STI_W), MSB first.
- res_rd, output, 1, result RAM read enable.
- res_wr, output, 1, result RAM write enable.
- res_addr, output, RES_AW, pixel address y*IMG_W+x.
- res_do, output, DIST_W, write data.
- res_di, input, DIST_W, read data.
- fwpass_finish, output, 1, level; high after the last forward-pass write.
- done, output, 1, level; high after the last backward-pass write.

Behaviour:
- Reset is asynchronous, active-low, on clock clk. While reset is low, all outputs are 0, the FSM is in IDLE and all counters are 0.
- A run starts automatically on the first clk after reset deasserts. done and fwpass_finish hold high until the next reset.
- Memory timing:
  - A read issued at posedge N (rd=1, addr valid) returns data sampled by the memory at the following negedge. The DUT uses that data at posedge N+1.
  - A write is performed at the posedge where res_wr=1.
  - At most one res_rd or res_wr per cycle; res_rd and res_wr are never high together.
- FSM states: IDLE -> FW_FETCH -> FW_NB -> FW_WR -> (next pixel) ... -> BW_CUR -> BW_NB -> BW_WR -> ... -> DONE.
- FW_FETCH:
  - Issue sti_rd when x mod STI_W == 0; the fetched word is held in a register.
  - Background pixel: write 0 and advance.
- FW_NB (forward pass, raster order y=0..IMG_H-1, x=0..IMG_W-1, object pixels only):
  - mode 1 reads NW, N, NE, W; mode 0 reads N, W. One neighbour read per cycle.
  - Neighbours outside the image are treated as 0 and are not read.
- FW_WR: write min(neighbours)+1, saturated.
- Pass transition: after pixel (IMG_W-1, IMG_H-1) is written, fwpass_finish rises the next cycle and the backward pass starts.
- Backward pass, reverse raster from (IMG_W-1, IMG_H-1) to (0,0):
  - BW_CUR reads the current pixel. Value 0 skips the pixel (no write).
  - BW_NB: mode 1 reads E, SW, S, SE; mode 0 reads E, S. Out-of-image neighbours count as 0.
  - BW_WR: write min(cur, min(neighbours)+1), saturated. The write is issued even if unchanged.
- done rises the cycle after the (0,0) pixel completes. All enables are 0 in DONE.
- Arithmetic: the +1 is computed at DIST_W+1 bits, then clamped to 2^DIST_W-1.
- Latency upper bound per pixel: 6 cycles forward, 6 cycles backward. Total run < 12*IMG_W*IMG_H + 16 cycles.
- Changes to mode after the start sample are ignored until the next reset.
- Reset low mid-run: immediate abort, all outputs 0. The RAM contents are not cleared by the DUT. The run restarts from pixel 0 after release.

Test Plan:
- IMG_W=IMG_H=16, STI_W=16, DIST_W=8, all-zero image -> all 256 res = 0; fwpass_finish rises before done; no res_wr after done.
- Single object pixel at (5,5), either mode -> res[85]=1, all others 0.
- Object rows/cols 4..8 (5x5 square), mode=1 -> res(6,6)=3, res(5,5)=2, res(4,4)=1, res(8,6)=1, outside 0.
- Object rows/cols 1..14 except background at (8,8):
  - mode=1 -> res(9,9)=1.
  - Repeated with mode=0 -> res(9,9)=2.
  - Border ring (x or y = 1 or 14) = 1 in both modes.
- DIST_W=3, all-ones 16x16, mode=1 -> res(0,0)=1, res(7,7)=7 (saturated from 8), no value exceeds 7.
- Assert reset low during the backward pass of the square case -> all outputs 0 within the same cycle; after release, done reasserts and results equal the square expectations.

Source files
------------

// File: rtl/dt_engine_param.sv
// Two-pass chamfer distance transform over a packed binary image.
// Forward pass scans raster order, backward pass scans reverse raster order.
module dt_engine_param #(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned STI_W  = 16,
    parameter int unsigned DIST_W = 8,
    parameter int unsigned STI_AW = $clog2(IMG_W * IMG_H / STI_W),
    parameter int unsigned RES_AW = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    output logic              sti_rd,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              res_rd,
    output logic              res_wr,
    output logic [RES_AW-1:0] res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di,
    output logic              fwpass_finish,
    output logic              done
);

    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BW = (STI_W > 1) ? $clog2(STI_W) : 1;

    localparam logic [XW-1:0]     XMax    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     YMax    = YW'(IMG_H - 1);
    localparam logic [BW-1:0]     BMax    = BW'(STI_W - 1);
    localparam logic [RES_AW-1:0] PixLast = RES_AW'(IMG_W * IMG_H - 1);
    localparam logic [RES_AW-1:0] PixOne  = RES_AW'(1);
    localparam logic [RES_AW-1:0] RowOff  = RES_AW'(IMG_W);
    localparam logic [DIST_W-1:0] DistMax = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] DistOne = DIST_W'(1);

    typedef enum logic [2:0] {
        StIdle, StFwFetch, StFwNb, StFwWr, StBwCur, StBwNb, StBwWr, StDone
    } state_e;

    state_e            state_q;
    logic              mode_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [BW-1:0]     bit_q;
    logic [RES_AW-1:0] pix_q;
    logic [STI_W-1:0]  word_q;
    logic [DIST_W-1:0] min_q;
    logic [DIST_W-1:0] cur_q;
    logic [1:0]        nb_cnt_q;

    logic [STI_W-1:0]  word;
    logic              pix_bit;
    logic [DIST_W-1:0] nb_min;
    logic [DIST_W:0]   sum;
    logic [DIST_W-1:0] plus1;
    logic [DIST_W-1:0] bw_val;
    logic              fw_border;
    logic              bw_border;
    logic [1:0]        nb_last;
    logic [XW-1:0]     x_next;
    logic [YW-1:0]     y_next;
    logic [XW-1:0]     x_prev;
    logic [YW-1:0]     y_prev;

    // Neighbour list per pass and metric; index k selects the k-th read.
    function automatic logic [RES_AW-1:0] nb_addr(input logic bw, input logic m,
                                                  input logic [1:0] k,
                                                  input logic [RES_AW-1:0] p);
        logic [RES_AW-1:0] a;
        a = p;
        if (!bw) begin
            if (m) begin
                case (k)
                    2'd0:    a = p - RowOff - PixOne;
                    2'd1:    a = p - RowOff;
                    2'd2:    a = p - RowOff + PixOne;
                    default: a = p - PixOne;
                endcase
            end else begin
                a = (k == 2'd0) ? p - RowOff : p - PixOne;
            end
        end else begin
            if (m) begin
                case (k)
                    2'd0:    a = p + PixOne;
                    2'd1:    a = p + RowOff - PixOne;
                    2'd2:    a = p + RowOff;
                    default: a = p + RowOff + PixOne;
                endcase
            end else begin
                a = (k == 2'd0) ? p + PixOne : p + RowOff;
            end
        end
        return a;
    endfunction

    always_comb begin
        word    = sti_rd ? sti_di : word_q;
        pix_bit = word[BMax - bit_q];
        nb_min  = (res_di < min_q) ? res_di : min_q;
        sum     = {1'b0, nb_min} + {{DIST_W{1'b0}}, 1'b1};
        plus1   = sum[DIST_W] ? DistMax : sum[DIST_W-1:0];
        bw_val  = (cur_q < plus1) ? cur_q : plus1;
        // Any out-of-image neighbour is 0, so such pixels resolve to 1 without reads.
        fw_border = (y_q == '0) || (x_q == '0) || (mode_q && (x_q == XMax));
        bw_border = (y_q == YMax) || (x_q == XMax) || (mode_q && (x_q == '0));
        nb_last   = mode_q ? 2'd3 : 2'd1;
        x_next    = (x_q == XMax) ? '0 : x_q + XW'(1);
        y_next    = (x_q == XMax) ? y_q + YW'(1) : y_q;
        x_prev    = (x_q == '0) ? XMax : x_q - XW'(1);
        y_prev    = (x_q == '0) ? y_q - YW'(1) : y_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            bit_q         <= '0;
            pix_q         <= '0;
            word_q        <= '0;
            min_q         <= '0;
            cur_q         <= '0;
            nb_cnt_q      <= '0;
            sti_rd        <= 1'b0;
            sti_addr      <= '0;
            res_rd        <= 1'b0;
            res_wr        <= 1'b0;
            res_addr      <= '0;
            res_do        <= '0;
            fwpass_finish <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    mode_q   <= mode;
                    sti_rd   <= 1'b1;
                    sti_addr <= '0;
                    state_q  <= StFwFetch;
                end
                StFwFetch: begin
                    sti_rd <= 1'b0;
                    if (sti_rd) word_q <= sti_di;
                    if (!pix_bit || fw_border) begin
                        res_wr   <= 1'b1;
                        res_addr <= pix_q;
                        res_do   <= pix_bit ? DistOne : '0;
                        state_q  <= StFwWr;
                    end else begin
                        min_q    <= DistMax;
                        nb_cnt_q <= '0;
                        res_rd   <= 1'b1;
                        res_addr <= nb_addr(1'b0, mode_q, 2'd0, pix_q);
                        state_q  <= StFwNb;
                    end
                end
                StFwNb: begin
                    min_q <= nb_min;
                    if (nb_cnt_q == nb_last) begin
                        res_rd   <= 1'b0;
                        res_wr   <= 1'b1;
                        res_addr <= pix_q;
                        res_do   <= plus1;
                        state_q  <= StFwWr;
                    end else begin
                        nb_cnt_q <= nb_cnt_q + 2'd1;
                        res_addr <= nb_addr(1'b0, mode_q, nb_cnt_q + 2'd1, pix_q);
                    end
                end
                StFwWr: begin
                    res_wr <= 1'b0;
                    if (pix_q == PixLast) begin
                        fwpass_finish <= 1'b1;
                        res_rd        <= 1'b1;
                        res_addr      <= pix_q;
                        state_q       <= StBwCur;
                    end else begin
                        pix_q <= pix_q + PixOne;
                        x_q   <= x_next;
                        y_q   <= y_next;
                        if (bit_q == BMax) begin
                            bit_q    <= '0;
                            sti_rd   <= 1'b1;
                            sti_addr <= sti_addr + STI_AW'(1);
                        end else begin
                            bit_q <= bit_q + BW'(1);
                        end
                        state_q <= StFwFetch;
                    end
                end
                StBwCur: begin
                    cur_q <= res_di;
                    if (res_di == '0) begin
                        if (pix_q == '0) begin
                            res_rd  <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            pix_q    <= pix_q - PixOne;
                            x_q      <= x_prev;
                            y_q      <= y_prev;
                            res_addr <= pix_q - PixOne;
                        end
                    end else if (bw_border) begin
                        res_rd   <= 1'b0;
                        res_wr   <= 1'b1;
                        res_addr <= pix_q;
                        res_do   <= DistOne;
                        state_q  <= StBwWr;
                    end else begin
                        min_q    <= DistMax;
                        nb_cnt_q <= '0;
                        res_addr <= nb_addr(1'b1, mode_q, 2'd0, pix_q);
                        state_q  <= StBwNb;
                    end
                end
                StBwNb: begin
                    min_q <= nb_min;
                    if (nb_cnt_q == nb_last) begin
                        res_rd   <= 1'b0;
                        res_wr   <= 1'b1;
                        res_addr <= pix_q;
                        res_do   <= bw_val;
                        state_q  <= StBwWr;
                    end else begin
                        nb_cnt_q <= nb_cnt_q + 2'd1;
                        res_addr <= nb_addr(1'b1, mode_q, nb_cnt_q + 2'd1, pix_q);
                    end
                end
                StBwWr: begin
                    res_wr <= 1'b0;
                    if (pix_q == '0) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        pix_q    <= pix_q - PixOne;
                        x_q      <= x_prev;
                        y_q      <= y_prev;
                        res_rd   <= 1'b1;
                        res_addr <= pix_q - PixOne;
                        state_q  <= StBwCur;
                    end
                end
                StDone: begin
                    sti_rd <= 1'b0;
                    res_rd <= 1'b0;
                    res_wr <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
